vga_line_fetch: RTL

Line-buffer fill engine that sits directly upstream of the VGA scan-out driver. On each per-buffer fill request from the driver it reads one display line of RGB565 pixels from the framebuffer memory arbiter in fixed-length bursts. It writes those pixels into ping-pong line buffer A or B through their write ports. Runs entirely in the pixel-clock domain.

---
 rtl/vga_line_fetch.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vga_line_fetch.sv
// Line-buffer fill engine: on a ping-pong buffer request, reads one RGB565 display
// line from the framebuffer arbiter in fixed bursts and streams it into buffer A or B.
module vga_line_fetch #(
  parameter logic [23:0] FB_BASE     = 24'h000000,
  parameter logic [23:0] LINE_STRIDE = 24'd1024,
  parameter int          BURST_LEN   = 16,
  parameter int          DATA_W      = 16
) (
  input  logic              vga_clk,
  input  logic              rst_n_w,
  input  logic              vga_mode,
  input  logic              buf_a_req,
  input  logic              buf_b_req,
  input  logic [9:0]        line_addr,
  output logic              mem_rd_req,
  output logic [23:0]       mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [9:0]        buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              buf_wr_en_a,
  output logic              buf_wr_en_b,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              overrun
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Word address of pixel off on display line ln; wraps modulo 2^24.
  function automatic logic [23:0] line_word_addr(input logic [9:0] ln, input logic [10:0] off);
    logic [23:0] prod;
    prod = 24'(ln) * LINE_STRIDE;
    return FB_BASE + prod + {13'd0, off};
  endfunction

  logic           req_a_d, req_b_d;
  logic           va_p0, vb_p0;
  logic [9:0]     line_p0;
  logic           line_ok;

  logic           pend_vld, pend_sel;
  logic [9:0]     pend_line;

  logic           buf_sel;
  logic [9:0]     line_r;
  logic [10:0]    px_total;
  logic [10:0]    pix_off;
  logic [BCW-1:0] beat_cnt;

  logic           can_start, use_pend, start_a, start_b, start;
  logic           start_sel;
  logic [9:0]     start_line;
  logic           left_a, left_b, pend_wr, pend_wr_sel;
  logic           beat_in, burst_end, line_end;
  logic [10:0]    pix_next;

  // Blanking-period lines are filtered here so they never start or queue a fill.
  always_comb begin
    line_ok = vga_mode ? (line_addr < 10'd768) : (line_addr < 10'd480);
  end

  // ---- stage p0: request edge detection ----
  always_ff @(posedge vga_clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      req_a_d <= 1'b0;
      req_b_d <= 1'b0;
      va_p0   <= 1'b0;
      vb_p0   <= 1'b0;
    end else begin
      req_a_d <= buf_a_req;
      req_b_d <= buf_b_req;
      va_p0   <= buf_a_req & ~req_a_d & line_ok;
      vb_p0   <= buf_b_req & ~req_b_d & line_ok;
    end
  end

  always_comb begin
    can_start   = (state_q == IDLE) || (state_q == DONE);
    use_pend    = can_start & pend_vld;
    start_a     = can_start & ~pend_vld & va_p0;
    start_b     = can_start & ~pend_vld & ~va_p0 & vb_p0;
    start       = use_pend | start_a | start_b;
    start_sel   = use_pend ? pend_sel : start_b;
    start_line  = use_pend ? pend_line : line_p0;
    // Any valid rise that did not start a fill this cycle lands in the pending slot.
    left_a      = va_p0 & ~start_a;
    left_b      = vb_p0 & ~start_b;
    pend_wr     = left_a | left_b;
    pend_wr_sel = ~left_a;
    beat_in     = (state_q == DATA) & mem_rd_valid;
    burst_end   = beat_in & (beat_cnt == BEAT_LAST);
    pix_next    = pix_off + 11'd1;
    line_end    = (pix_next == px_total);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ:  if (mem_rd_ack) state_d = DATA;
      DATA: if (burst_end) state_d = line_end ? DONE : REQ;
      DONE: state_d = start ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      state_q     <= IDLE;
      pend_vld    <= 1'b0;
      pend_sel    <= 1'b0;
      buf_sel     <= 1'b0;
      px_total    <= 11'd0;
      pix_off     <= 11'd0;
      beat_cnt    <= '0;
      mem_rd_addr <= 24'd0;
      overrun     <= 1'b0;
      fill_done   <= 1'b0;
      buf_wr_en_a <= 1'b0;
      buf_wr_en_b <= 1'b0;
      buf_wr_addr <= 10'd0;
      buf_wr_data <= '0;
    end else begin
      state_q <= state_d;

      if (pend_wr) begin
        pend_vld <= 1'b1;
        pend_sel <= pend_wr_sel;
      end else if (use_pend) begin
        pend_vld <= 1'b0;
      end

      overrun   <= pend_wr & (state_q != IDLE);
      fill_done <= (state_q == DONE);

      if (start) begin
        buf_sel     <= start_sel;
        px_total    <= vga_mode ? 11'd1024 : 11'd640;
        pix_off     <= 11'd0;
        mem_rd_addr <= line_word_addr(start_line, 11'd0);
      end else if (beat_in) begin
        pix_off <= pix_next;
        if (burst_end && !line_end)
          mem_rd_addr <= line_word_addr(line_r, pix_next);
      end

      if ((state_q == REQ) && mem_rd_ack)
        beat_cnt <= '0;
      else if (beat_in)
        beat_cnt <= beat_cnt + BCW'(1);

      // ---- stage p1: buffer write port ----
      buf_wr_en_a <= beat_in & ~buf_sel;
      buf_wr_en_b <= beat_in & buf_sel;
      if (beat_in) begin
        buf_wr_addr <= pix_off[9:0];
        buf_wr_data <= mem_rd_data;
      end
    end
  end

  // Datapath holding registers; always qualified by control before use.
  always_ff @(posedge vga_clk) begin
    line_p0 <= line_addr;
    if (pend_wr) pend_line <= line_p0;
    if (start) line_r <= start_line;
  end

  assign mem_rd_req = (state_q == REQ);
  assign fill_busy  = (state_q != IDLE);

endmodule
